// File: rtl/lfsr_gen.sv
// lfsr_gen -- parametrised Fibonacci XNOR LFSR word generator.
//
// Produces pseudo-random words on a valid/ready interface. The seed can be
// loaded at run time. Loading the XNOR lock-up value (all-ones) parks the
// generator in a fault state until a legal seed is loaded. A counter tracks
// the number of words accepted since reset or the last seed load.
//
// Parameters:
//   WIDTH      register width, 4..64
//   TAPS       feedback tap mask (bit i set => state[i] feeds back); only the
//              low WIDTH bits are used
//   RESET_SEED state after reset (low WIDTH bits); must not be all-ones
//   STEPS      single-bit shifts per advance, 1..WIDTH
//   CNT_W      width of the accepted-word counter
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   enable      run request; low holds the state
//   seed_load   load seed_in into the state this cycle
//   seed_in     seed value
//   out_ready   consumer accepts out_data
//   out_valid   out_data holds an unconsumed word
//   out_data    current LFSR state
//   lockup      the loaded seed was the lock-up value
//   word_count  accepted words since reset/load, wraps silently
module lfsr_gen #(
  parameter int          WIDTH      = 64,
  parameter logic [63:0] TAPS       = 64'hD800_0000_0000_0000,
  parameter logic [63:0] RESET_SEED = 64'd0,
  parameter int          STEPS      = 1,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED0    = RESET_SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Parameter sanity checks, reported at elaboration.
  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 4..64");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..WIDTH");
  end
  if (SEED0 == ALL_ONES) begin : g_bad_seed
    $error("lfsr_gen: RESET_SEED must not be the all-ones lock-up value");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           fsm_reg, fsm_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             lockup_reg, lockup_next;
  logic [WIDTH-1:0] adv;

  // Unrolled chain of STEPS single shifts. Each stage shifts left and
  // inserts the XNOR of the tapped bits at bit 0; the whole chain settles
  // within one cycle.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    if (gi == 0) begin : g_first
      assign src = data_reg;
    end else begin : g_rest
      assign src = g_step[gi-1].dst;
    end
    assign dst = {src[WIDTH-2:0], ~(^(src & TAP_MASK))};
  end
  assign adv = g_step[STEPS-1].dst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_reg    <= IDLE;
      data_reg   <= SEED0;
      count_reg  <= '0;
      lockup_reg <= 1'b0;
    end else begin
      fsm_reg    <= fsm_next;
      data_reg   <= data_next;
      count_reg  <= count_next;
      lockup_reg <= lockup_next;
    end
  end

  always_comb begin
    fsm_next    = fsm_reg;
    data_next   = data_reg;
    count_next  = count_reg;
    lockup_next = lockup_reg;
    out_valid   = (fsm_reg == RUN);

    // A seed load overrides everything, including a handshake in the same
    // cycle: that word is neither counted nor advanced past.
    if (seed_load) begin
      data_next  = seed_in;
      count_next = '0;
      if (seed_in == ALL_ONES) begin
        fsm_next    = FAULT;
        lockup_next = 1'b1;
      end else begin
        lockup_next = 1'b0;
        fsm_next    = enable ? RUN : IDLE;
      end
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (enable) fsm_next = RUN;
        end
        RUN: begin
          if (!enable) begin
            fsm_next = IDLE;
          end else if (out_ready) begin
            // out_valid is 1 in RUN, so out_ready completes a transfer.
            data_next  = adv;
            count_next = count_reg + CNT_W'(1);
          end
        end
        FAULT: begin
          // Only a legal seed load leaves FAULT.
        end
        default: begin
          fsm_next = IDLE;
        end
      endcase
    end
  end

  assign out_data   = data_reg;
  assign lockup     = lockup_reg;
  assign word_count = count_reg;

endmodule
